// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle instruction phase controller: FETCH/DECODE/EXEC/[MEM]/WB sequencing,
// one-cycle datapath enables, and a data-memory handshake with a bounded wait.
module cpu_phase_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [4:0]  HALT_OPCODE = 5'h1F,
  parameter int unsigned RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [4:0]          opcode,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                regwrite,
  input  logic                mem_ready,
  output logic                en_fetch_pulse,
  output logic                en_exe_pulse,
  output logic                mem_req,
  output logic                mem_load,
  output logic                mem_store,
  output logic                en_wb_pulse,
  output logic                en_pc_pulse,
  output logic [2:0]          phase,
  output logic                halted,
  output logic                mem_timeout,
  output logic [RETIRE_W-1:0] retired_count
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                lat_load, lat_store, lat_regwrite;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                wait_done;

  assign wait_done = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Wait counter is held at zero outside MEM, so every MEM entry starts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_load     <= 1'b0;
      lat_store    <= 1'b0;
      lat_regwrite <= 1'b0;
      wait_cnt     <= '0;
      timeout_q    <= 1'b0;
      retired_q    <= '0;
    end else begin
      if (state_q == S_DECODE) begin
        lat_load     <= is_load;
        lat_store    <= is_store;
        lat_regwrite <= regwrite;
      end
      if (state_q == S_MEM && !mem_ready && !wait_done) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                              wait_cnt <= '0;
      if (state_q == S_MEM && !mem_ready && wait_done) timeout_q <= 1'b1;
      if (state_q == S_WB) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    en_fetch_pulse = 1'b0;
    en_exe_pulse   = 1'b0;
    mem_req        = 1'b0;
    mem_load       = 1'b0;
    mem_store      = 1'b0;
    en_wb_pulse    = 1'b0;
    en_pc_pulse    = 1'b0;
    halted         = 1'b0;
    phase          = state_q;
    mem_timeout    = timeout_q;
    retired_count  = retired_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        en_fetch_pulse = 1'b1;
        state_d        = S_DECODE;
      end
      S_DECODE: state_d = (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
      S_EXEC: begin
        en_exe_pulse = 1'b1;
        state_d      = (lat_load || lat_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_load  = lat_load;
        mem_store = lat_store && !lat_load;
        if (mem_ready)      state_d = S_WB;
        else if (wait_done) state_d = S_HALT;
      end
      S_WB: begin
        en_pc_pulse = 1'b1;
        en_wb_pulse = lat_regwrite;
        state_d     = run ? S_FETCH : S_IDLE;
      end
      S_HALT:   halted  = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
Multi-cycle phase controller for the 32-bit CPU. It sequences each instruction through FETCH, DECODE, EXECUTE, optional MEMORY and WRITEBACK. It generates the one-cycle enable pulses (fetch, execute, PC update, register commit) and runs a data-memory request/ready handshake with timeout. It sits between the control unit (opcode and class flags) and the datapath, PC and memory interface.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent in MEM waiting for mem_ready before a fault (>=1)
HALT_OPCODE, 5'h1F, opcode that stops the sequencer
RETIRE_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  level enable; start and continue issuing instructions while high
opcode  in  5  opcode from the control unit; sampled in DECODE only
is_load  in  1  instruction is a load; sampled in DECODE
is_store  in  1  instruction is a store; sampled in DECODE
regwrite  in  1  instruction writes Rd; sampled in DECODE
mem_ready  in  1  memory completion; sampled in MEM only
en_fetch_pulse  out  1  latch Instruction; high for exactly the FETCH cycle
en_exe_pulse  out  1  ALU/flag update; high for exactly the EXEC cycle
mem_req  out  1  high for every MEM cycle
mem_load  out  1  mem_req and latched load
mem_store  out  1  mem_req and latched store and not latched load
en_wb_pulse  out  1  register-file commit; high in WB when latched regwrite=1
en_pc_pulse  out  1  PC advance; high for exactly the WB cycle
phase  out  3  current state encoding
halted  out  1  high while in HALT
mem_timeout  out  1  sticky fault flag
retired_count  out  RETIRE_W  instructions completed through WB; wraps modulo 2^RETIRE_W

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Codes 7 and any other illegal value go to IDLE on the next edge.
- All outputs decode combinationally from registered state, latched flags and registers. There is no combinational path from any input to any output.
- Reset (async): state=IDLE. Latched flags, wait counter, mem_timeout and retired_count are 0. Every output is 0 while reset is high, including immediately on assertion mid-instruction.
- IDLE: go to FETCH if run=1, else stay.
- FETCH: one cycle, then DECODE.
- DECODE:
  - Latch is_load, is_store and regwrite.
  - If opcode==HALT_OPCODE, go to HALT. No exe, pc or wb pulse is issued and retired_count does not change.
  - Otherwise go to EXEC.
- EXEC: one cycle. Go to MEM if latched load or store, else go to WB.
- MEM:
  - The wait counter clears to 0 on entry.
  - mem_ready=1 in any MEM cycle: go to WB.
  - mem_ready=0 and wait counter == MEM_TIMEOUT-1: set mem_timeout=1 and go to HALT.
  - mem_ready=0 otherwise: increment the wait counter and stay.
  - At most MEM_TIMEOUT MEM cycles. mem_ready=1 on the final allowed cycle wins over timeout.
- WB:
  - en_pc_pulse=1.
  - en_wb_pulse = latched regwrite.
  - retired_count increments by 1 on the exit edge.
  - Then go to FETCH if run=1, else IDLE.
- run is checked only in IDLE and WB. Deasserting run mid-instruction lets that instruction complete.
- HALT: halted=1 and all pulses are 0. Stays in HALT regardless of run; only reset exits.
- Latency: non-memory instruction = 4 cycles (FETCH→WB). Memory instruction = 5 + N cycles, where N is the number of mem_ready-low MEM cycles.
- Load and store both latched: treated as a load (mem_load=1, mem_store=0).

Test Plan:
1. Reset, then run=1, opcode=5'h0A, no load/store, regwrite=1 → en_fetch_pulse in cycle 1, phase 2 in cycle 2, en_exe_pulse in cycle 3, en_wb_pulse and en_pc_pulse in cycle 4; FETCH again in cycle 5; retired_count=1.
2. Load with mem_ready held low for 3 MEM cycles, high on the 4th → mem_req and mem_load high for 4 cycles, mem_store=0; then WB; 8 cycles FETCH→WB in total; retired_count increments.
3. Store with mem_ready stuck at 0 → exactly 15 MEM cycles, then mem_timeout=1, halted=1, phase=6, mem_req=0, retired_count unchanged; mem_timeout persists until reset.
4. opcode=5'h1F → HALT directly after DECODE with no exe/pc/wb pulse. halted stays 1 while run toggles 0→1→0. Reset returns phase to 0.
5. Assert reset during the 2nd MEM cycle → mem_req, mem_load and phase drop to 0 without waiting for a clock edge. Release with run=1 → FETCH on the first edge after release.
6. Deassert run during EXEC of a regwrite=0 ALU instruction → WB has en_pc_pulse=1 and en_wb_pulse=0, then IDLE, with no further en_fetch_pulse until run returns to 1.
